// File: rtl/ysyx_22040088_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_22040088_ifu_if
// Bundles the IFU's instruction-memory port, its decode-side port and its
// status/debug outputs.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised, it and its payload stay stable until
// that edge; valid is never withdrawn early. The producer never looks at
// ready before it raises valid. imem_resp_valid is a one-cycle pulse with no
// ready; the IFU only listens for it while it is waiting for a response.
//
// modport master : IFU side (drives requests, instruction, status).
// modport slave  : environment side (memory, decode/execute).
// ----------------------------------------------------------------------------
interface ysyx_22040088_ifu_if;
  // instruction memory request/response
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  // decode/execute handoff
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] next_pc;
  logic        next_pc_valid;
  // status and debug
  logic        fetch_err;
  logic [63:0] fetch_cnt;
  logic [2:0]  state_dbg;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc, opcode, funct3, funct7,
    input  inst_ready, next_pc, next_pc_valid,
    output fetch_err, fetch_cnt, state_dbg
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc, opcode, funct3, funct7,
    output inst_ready, next_pc, next_pc_valid,
    input  fetch_err, fetch_cnt, state_dbg
  );
endinterface

// File: rtl/ysyx_22040088_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040088_ifu
// Instruction fetch unit for the ysyx_22040088 RV64 core. Holds the PC,
// fetches one 32-bit instruction per request from instruction memory, hands
// it (with its PC and decoder fields) to decode, then waits for execute to
// return the next PC. A misaligned next PC parks the unit in an error state
// that only reset leaves.
//
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - ysyx_22040088_ifu_if.master: imem req/resp, inst handoff,
//          next_pc return, fetch_err, fetch_cnt, state_dbg (FSM state)
//
// Every output is a register or a decode of the state register, so there
// is no combinational input-to-output path.
// ----------------------------------------------------------------------------
module ysyx_22040088_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000  // must be 4-byte aligned
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_22040088_ifu_if.master   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic [63:0] fetch_cnt_q, fetch_cnt_d;

  // The next PC is taken either together with the decode handshake or
  // later from S_EXEC; both cases share one alignment check.
  logic take_next_pc;

  always_comb begin
    take_next_pc = ((state_q == S_VALID) && bus.inst_ready && bus.next_pc_valid) ||
                   ((state_q == S_EXEC) && bus.next_pc_valid);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          inst_d    = bus.imem_resp_data;
          // pc_q only changes after the instruction is consumed, so it is
          // still the address this response belongs to.
          inst_pc_d = pc_q;
          state_d   = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.inst_ready) begin
          fetch_cnt_d = fetch_cnt_q + 64'd1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: state_d = S_EXEC;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    if (take_next_pc) begin
      if (bus.next_pc[1:0] == 2'b00) begin
        pc_d    = bus.next_pc;
        state_d = S_REQ;
      end else begin
        // pc keeps the address of the last good fetch
        state_d = S_ERR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= NOP;
      inst_pc_q   <= RESET_PC;
      fetch_cnt_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_VALID);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.opcode         = inst_q[6:0];
  assign bus.funct3         = inst_q[14:12];
  assign bus.funct7         = inst_q[31:25];
  assign bus.fetch_err      = (state_q == S_ERR);
  assign bus.fetch_cnt      = fetch_cnt_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: doc/ysyx_22040088_ifu.md
# ysyx_22040088_ifu

Instruction fetch unit for the ysyx_22040088 RV64 core. It holds the architectural PC and fetches one 32-bit instruction at a time from instruction memory over a valid/ready request and response interface. It presents the instruction, its PC and the decoder fields (opcode, funct3, funct7) to the decode/control stage through a valid/ready handshake. It then waits for the execute stage to return the next PC, which the core computes from sel_nextpc.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset; must be 4-byte aligned

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  fetch address (current PC)
- imem_resp_valid  in  1  instruction data valid (one-cycle pulse per request)
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode/execute consumes instruction
- inst  out  32  captured instruction word
- inst_pc  out  64  PC of inst
- opcode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- next_pc  in  64  next PC from execute
- next_pc_valid  in  1  next_pc valid this cycle
- fetch_err  out  1  sticky misaligned-PC error
- fetch_cnt  out  64  count of instructions handed to decode

## Operation
- State machine: S_IDLE, S_REQ, S_WAIT, S_VALID, S_EXEC, S_ERR.
- S_IDLE: entered on reset; moves to S_REQ unconditionally on the next edge.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, moves to S_WAIT.
  - Address and valid stay stable until accepted; a request is never withdrawn.
- S_WAIT: on imem_resp_valid, latches inst<=imem_resp_data and moves to S_VALID.
- S_VALID:
  - inst_valid=1; inst, inst_pc, opcode, funct3 and funct7 are stable.
  - On inst_ready: fetch_cnt increments by 1 (64-bit, wraps 2^64-1 -> 0).
    - If next_pc_valid is also high in the same cycle, the next_pc check (below) applies and S_EXEC is skipped.
    - Otherwise the state moves to S_EXEC.
- S_EXEC: on next_pc_valid, applies the next_pc check.
- next_pc check:
  - next_pc[1:0]==0: pc<=next_pc, move to S_REQ.
  - next_pc[1:0]!=0: move to S_ERR; pc is unchanged.
- S_ERR: fetch_err=1; no requests are issued and inst_valid=0. Only reset exits this state.
- Ignored inputs:
  - imem_resp_valid outside S_WAIT.
  - next_pc_valid outside S_VALID (with inst_ready) and S_EXEC.
  - inst_ready outside S_VALID.
- inst, inst_pc and the decoder fields hold their last values in every state. They are only meaningful while inst_valid=1.
- The opcode, funct3 and funct7 outputs are pure slices of the inst register.

## Timing
- Reset values (asynchronous):
  - state=S_IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), fetch_cnt=0.
  - imem_req_valid=0, inst_valid=0, fetch_err=0.
  - imem_req_addr=RESET_PC, inst_pc=RESET_PC.
- After rst deasserts, imem_req_valid rises at the second rising edge.
- Fast path, with req accepted at cycle N and resp at N+1:
  - inst_valid=1 at N+2.
  - With inst_ready and next_pc_valid both high at N+2, the next request is valid at N+3.
  - Minimum fetch period is 3 cycles.
- A response in the same cycle as request acceptance is ignored; the earliest response is the cycle after acceptance.
- Reset mid-operation (any state, including with an outstanding request) returns all state to reset values immediately. A late response after reset is ignored because the state is not S_WAIT.
- Outputs are registered or decoded only from state and registers. There is no combinational path from any input to any output.

## Test plan
- Reset and first fetch:
  - Stimulus: rst pulse; imem_req_ready=1; resp 32'h00000513 one cycle after acceptance.
  - Required: req_addr=0x80000000; inst_valid two cycles after acceptance; opcode=7'h13, funct3=0, funct7=0; fetch_cnt=0 until handshake.
- Back-pressure:
  - Stimulus: hold imem_req_ready=0 for 5 cycles, then hold inst_ready=0 for 4 cycles.
  - Required: req_valid and req_addr stay stable throughout; inst and inst_pc stay stable; fetch_cnt increments exactly once after inst_ready.
- Sequential stream:
  - Stimulus: 10 instructions with next_pc=pc+4, given with inst_ready and next_pc_valid in the same cycle.
  - Required: addresses 0x80000000..0x80000024; fetch_cnt=10; 3-cycle period.
- Branch redirect via S_EXEC:
  - Stimulus: inst_ready without next_pc_valid, then next_pc=0x80001000 two cycles later.
  - Required: next request addr=0x80001000.
- Misaligned redirect:
  - Stimulus: next_pc=0x80000002.
  - Required: fetch_err=1; imem_req_valid stays 0; inst_valid stays 0 until rst; pc unchanged.
- Reset during S_WAIT:
  - Stimulus: rst asserted during S_WAIT, then a stale imem_resp_valid.
  - Required: outputs return to reset values; stale resp is ignored; the fresh fetch is from RESET_PC.
